// File: rtl/bank_stream_reader.sv
// ============================================================================
//  Module      : bank_stream_reader
//  Description : Reads a burst of coefficients from a synchronous bank
//                (1-cycle read latency) starting at base_addr and streams them
//                out over a valid/ready interface through a 2-entry FIFO.
//                Reads are throttled so the FIFO can never overflow, and a
//                full-throughput stream of one beat per cycle is sustained
//                when the consumer is always ready.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                start, base_addr,
//                len               - burst request (len = 0 .. 2^ADDR_WIDTH)
//                addr_read         - bank read address (held when idle)
//                bank_data         - bank read data, one cycle after address
//                m_data, m_valid,
//                m_ready, m_last   - output stream
//                busy, done        - burst in progress / completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_stream_reader #(
   parameter int DATA_WIDTH = 54,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic [ADDR_WIDTH-1:0] addr_read,
   input  logic [DATA_WIDTH-1:0] bank_data,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                  state;
   state_t                  state_next;
   logic [ADDR_WIDTH-1:0]   next_addr;      // address of the next read to issue
   logic [ADDR_WIDTH-1:0]   held_addr;      // last issued address
   logic [ADDR_WIDTH:0]     issue_left;     // reads still to issue
   logic                    inflight;       // read issued last cycle
   logic                    inflight_last;  // that read is the final one
   logic [DATA_WIDTH-1:0]   fifo_data [2];
   logic [1:0]              fifo_last;
   logic                    wr_ptr;
   logic                    rd_ptr;
   logic [1:0]              fifo_count;
   logic                    done_r;

   logic                    accept;         // start accepted with non-zero len
   logic                    issue;
   logic                    pop;
   logic                    pop_last;
   logic [2:0]              occupancy;

   always_comb begin
      accept    = !rst && (state == IDLE) && start && (len != '0);
      pop       = !rst && (fifo_count != 2'd0) && m_ready;
      pop_last  = pop && fifo_last[rd_ptr];
      // Slots already claimed after this cycle's pop; a new read needs a free
      // slot for when its data lands next cycle.
      occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);
      issue     = !rst && (state == READ) && (issue_left != '0) && (occupancy < 3'd2);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = READ;
         READ:    if (issue && (issue_left == LEN_ONE)) state_next = DRAIN;
         DRAIN:   if (pop_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The issuing address is presented in the same cycle the read is issued,
   // so the bank returns its data exactly one cycle later.
   assign addr_read = rst ? '0 : (issue ? next_addr : held_addr);
   assign m_data    = fifo_data[rd_ptr];
   assign m_valid   = !rst && (fifo_count != 2'd0);
   assign m_last    = !rst && (fifo_count != 2'd0) && fifo_last[rd_ptr];
   assign busy      = !rst && (state != IDLE);
   assign done      = !rst && done_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         next_addr     <= '0;
         held_addr     <= '0;
         issue_left    <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         fifo_last     <= 2'b00;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         fifo_count    <= 2'd0;
         done_r        <= 1'b0;
      end else begin
         state  <= state_next;
         done_r <= pop_last || ((state == IDLE) && start && (len == '0));

         if (accept) begin
            next_addr  <= base_addr;
            issue_left <= len;
         end else if (issue) begin
            next_addr  <= next_addr + 1'b1;
            issue_left <= issue_left - 1'b1;
         end

         if (issue) held_addr <= next_addr;

         inflight      <= issue;
         inflight_last <= issue && (issue_left == LEN_ONE);

         if (inflight) begin
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;

         fifo_count <= fifo_count + 2'(inflight) - 2'(pop);
      end
   end

   // Data storage needs no reset: validity is tracked by fifo_count.
   always_ff @(posedge clk) begin
      if (!rst && inflight) fifo_data[wr_ptr] <= bank_data;
   end

endmodule

`default_nettype wire
